// File: rtl/pmp_pkg.sv
// Shared PMP encodings and the per-entry configuration record.
package pmp_pkg;
  localparam logic [1:0] PMP_OFF   = 2'd0;
  localparam logic [1:0] PMP_TOR   = 2'd1;
  localparam logic [1:0] PMP_NA4   = 2'd2;
  localparam logic [1:0] PMP_NAPOT = 2'd3;

  localparam logic [1:0] CMD_R = 2'd0;
  localparam logic [1:0] CMD_W = 2'd1;
  localparam logic [1:0] CMD_X = 2'd2;

  typedef struct packed {
    logic       l;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;
endpackage

// File: rtl/pmp_entry_match.sv
// One PMP entry: address match for TOR/NA4/NAPOT and the permission bit for the access type.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int PADDR_BITS = 32
) (
  input  logic [PADDR_BITS-1:0] i_addr,
  input  logic                  i_l,
  input  logic [1:0]            i_a,
  input  logic                  i_r,
  input  logic                  i_w,
  input  logic                  i_x,
  input  logic [PADDR_BITS-3:0] i_pmp_addr,
  input  logic [PADDR_BITS-3:0] i_prev_addr,
  input  logic [PADDR_BITS-1:0] i_mask,
  input  logic [1:0]            i_cmd,
  input  logic                  i_m_mode,
  output logic                  o_hit,
  output logic                  o_perm
);
  logic [PADDR_BITS-1:0] w_base;
  logic [PADDR_BITS-1:0] w_prev;
  logic                  w_tor_hit;
  logic                  w_nap_hit;
  logic                  w_perm_bit;

  assign w_base    = {i_pmp_addr, 2'b00};
  assign w_prev    = {i_prev_addr, 2'b00};
  assign w_tor_hit = (i_addr >= w_prev) && (i_addr < w_base);
  assign w_nap_hit = ((i_addr ^ w_base) & ~i_mask) == '0;

  // Select the match rule for the entry's mode
  always_comb begin
    o_hit = 1'b0;
    case (i_a)
      PMP_TOR:             o_hit = w_tor_hit;
      PMP_NA4, PMP_NAPOT:  o_hit = w_nap_hit;
      default:             o_hit = 1'b0;
    endcase
  end

  // Pick the permission bit for the command; reserved cmd behaves as a read
  always_comb begin
    w_perm_bit = i_r;
    case (i_cmd)
      CMD_W:   w_perm_bit = i_w;
      CMD_X:   w_perm_bit = i_x;
      default: w_perm_bit = i_r;
    endcase
  end

  // M-mode bypasses unlocked entries
  assign o_perm = w_perm_bit | (i_m_mode & ~i_l);
endmodule

// File: rtl/pmp_check_pipe.sv
// Two-stage PMP checker: S0 evaluates entries, S1 priority-encodes, S2 drives the response.
// Also holds a sticky first-denial record and a saturating denial counter.
module pmp_check_pipe
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int PADDR_BITS  = 32,
  parameter int CNT_BITS    = 16,
  localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [1:0]                           io_prv,
  input  logic [NUM_ENTRIES-1:0]               io_pmp_cfg_l,
  input  logic [2*NUM_ENTRIES-1:0]             io_pmp_cfg_a,
  input  logic [NUM_ENTRIES-1:0]               io_pmp_cfg_r,
  input  logic [NUM_ENTRIES-1:0]               io_pmp_cfg_w,
  input  logic [NUM_ENTRIES-1:0]               io_pmp_cfg_x,
  input  logic [NUM_ENTRIES*(PADDR_BITS-2)-1:0] io_pmp_addr,
  input  logic [NUM_ENTRIES*PADDR_BITS-1:0]    io_pmp_mask,
  input  logic                                 io_req_valid,
  output logic                                 io_req_ready,
  input  logic [PADDR_BITS-1:0]                io_req_addr,
  input  logic [1:0]                           io_req_cmd,
  output logic                                 io_resp_valid,
  input  logic                                 io_resp_ready,
  output logic                                 io_resp_allow,
  output logic                                 io_resp_hit,
  output logic [IDX_W-1:0]                     io_resp_idx,
  output logic                                 io_fault_valid,
  output logic [PADDR_BITS-1:0]                io_fault_addr,
  output logic [1:0]                           io_fault_cmd,
  input  logic                                 io_fault_clr,
  output logic [CNT_BITS-1:0]                  io_fault_count
);
  localparam int AW = PADDR_BITS - 2;

  logic [NUM_ENTRIES-1:0] w_hit, w_perm;
  logic                   w_s2_free, w_req_fire, w_deny_fire;
  logic                   w_s1_allow;
  logic [IDX_W-1:0]       w_s1_idx;
  logic                   w_unused;

  logic                   r_s1_v, r_s1_m;
  logic [PADDR_BITS-1:0]  r_s1_addr;
  logic [1:0]             r_s1_cmd;
  logic [NUM_ENTRIES-1:0] r_s1_hit, r_s1_perm;

  logic                   r_s2_v, r_s2_allow, r_s2_hit;
  logic [IDX_W-1:0]       r_s2_idx;
  logic [PADDR_BITS-1:0]  r_s2_addr;
  logic [1:0]             r_s2_cmd;

  logic                   r_fault_v;
  logic [PADDR_BITS-1:0]  r_fault_addr;
  logic [1:0]             r_fault_cmd;
  logic [CNT_BITS-1:0]    r_cnt;

  // Only the M-mode bit of the privilege matters to the check
  assign w_unused = io_prv[0];

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ent
    pmp_cfg_t        w_cfg;
    logic [AW-1:0]   w_prev;
    assign w_cfg = '{l: io_pmp_cfg_l[gi], a: io_pmp_cfg_a[2*gi +: 2],
                     x: io_pmp_cfg_x[gi], w: io_pmp_cfg_w[gi], r: io_pmp_cfg_r[gi]};
    if (gi == 0) begin : g_first
      assign w_prev = '0;
    end else begin : g_rest
      assign w_prev = io_pmp_addr[(gi-1)*AW +: AW];
    end
    pmp_entry_match #(.PADDR_BITS(PADDR_BITS)) u_match (
      .i_addr      (io_req_addr),
      .i_l         (w_cfg.l),
      .i_a         (w_cfg.a),
      .i_r         (w_cfg.r),
      .i_w         (w_cfg.w),
      .i_x         (w_cfg.x),
      .i_pmp_addr  (io_pmp_addr[gi*AW +: AW]),
      .i_prev_addr (w_prev),
      .i_mask      (io_pmp_mask[gi*PADDR_BITS +: PADDR_BITS]),
      .i_cmd       (io_req_cmd),
      .i_m_mode    (io_prv[1]),
      .o_hit       (w_hit[gi]),
      .o_perm      (w_perm[gi])
    );
  end

  // S2 can take new data when empty or draining; S1 may refill whenever it will move on
  assign w_s2_free    = !r_s2_v | io_resp_ready;
  assign io_req_ready = !r_s1_v | w_s2_free;
  assign w_req_fire   = io_req_valid & io_req_ready;
  assign w_deny_fire  = r_s2_v & io_resp_ready & ~r_s2_allow;

  // Lowest-index hit wins; no hit falls back to the M-mode default
  always_comb begin
    w_s1_idx   = '0;
    w_s1_allow = r_s1_m;
    for (int i = NUM_ENTRIES-1; i >= 0; i--) begin
      if (r_s1_hit[i]) begin
        w_s1_idx   = IDX_W'(i);
        w_s1_allow = r_s1_perm[i];
      end
    end
  end

  // S1: capture match/perm vectors so later config changes cannot affect this request
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_v    <= 1'b0;
      r_s1_m    <= 1'b0;
      r_s1_addr <= '0;
      r_s1_cmd  <= '0;
      r_s1_hit  <= '0;
      r_s1_perm <= '0;
    end else if (io_req_ready) begin
      r_s1_v <= io_req_valid;
      if (w_req_fire) begin
        r_s1_m    <= io_prv[1];
        r_s1_addr <= io_req_addr;
        r_s1_cmd  <= io_req_cmd;
        r_s1_hit  <= w_hit;
        r_s1_perm <= w_perm;
      end
    end
  end

  // S2: response register, held while the consumer stalls
  always_ff @(posedge clock) begin
    if (reset) begin
      r_s2_v     <= 1'b0;
      r_s2_allow <= 1'b0;
      r_s2_hit   <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_addr  <= '0;
      r_s2_cmd   <= '0;
    end else if (w_s2_free) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_allow <= w_s1_allow;
        r_s2_hit   <= |r_s1_hit;
        r_s2_idx   <= w_s1_idx;
        r_s2_addr  <= r_s1_addr;
        r_s2_cmd   <= r_s1_cmd;
      end
    end
  end

  // Sticky fault: keep the first denial; a clear in the same cycle lets a new one in
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fault_v    <= 1'b0;
      r_fault_addr <= '0;
      r_fault_cmd  <= '0;
    end else if (w_deny_fire && (!r_fault_v || io_fault_clr)) begin
      r_fault_v    <= 1'b1;
      r_fault_addr <= r_s2_addr;
      r_fault_cmd  <= r_s2_cmd;
    end else if (io_fault_clr) begin
      r_fault_v <= 1'b0;
    end
  end

  // Saturating count of delivered denials
  always_ff @(posedge clock) begin
    if (reset) r_cnt <= '0;
    else if (w_deny_fire && (r_cnt != '1)) r_cnt <= r_cnt + CNT_BITS'(1);
  end

  assign io_resp_valid  = r_s2_v;
  assign io_resp_allow  = r_s2_allow;
  assign io_resp_hit    = r_s2_hit;
  assign io_resp_idx    = r_s2_idx;
  assign io_fault_valid = r_fault_v;
  assign io_fault_addr  = r_fault_addr;
  assign io_fault_cmd   = r_fault_cmd;
  assign io_fault_count = r_cnt;
endmodule

// File: tb/tb_pmp_check_pipe.sv
// Scoreboard bench for pmp_check_pipe (8 entries, 4-bit counter so saturation is reachable).
module tb_pmp_check_pipe;
  localparam int NE = 8;
  localparam int PB = 32;
  localparam int CB = 4;

  typedef struct packed { logic allow; logic hit; logic [2:0] idx; } exp_t;

  logic clock, reset;
  logic [1:0] io_prv;
  logic [NE-1:0] cfg_l, cfg_r, cfg_w, cfg_x;
  logic [2*NE-1:0] cfg_a;
  logic [NE*(PB-2)-1:0] pmp_addr;
  logic [NE*PB-1:0] pmp_mask;
  logic io_req_valid, io_req_ready;
  logic [PB-1:0] io_req_addr;
  logic [1:0] io_req_cmd;
  logic io_resp_valid, io_resp_ready, io_resp_allow, io_resp_hit;
  logic [2:0] io_resp_idx;
  logic io_fault_valid, io_fault_clr;
  logic [PB-1:0] io_fault_addr;
  logic [1:0] io_fault_cmd;
  logic [CB-1:0] io_fault_count;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t obs;
  assign obs = {io_resp_allow, io_resp_hit, io_resp_idx};

  pmp_check_pipe #(.NUM_ENTRIES(NE), .PADDR_BITS(PB), .CNT_BITS(CB)) dut (
    .clock(clock), .reset(reset), .io_prv(io_prv),
    .io_pmp_cfg_l(cfg_l), .io_pmp_cfg_a(cfg_a), .io_pmp_cfg_r(cfg_r),
    .io_pmp_cfg_w(cfg_w), .io_pmp_cfg_x(cfg_x),
    .io_pmp_addr(pmp_addr), .io_pmp_mask(pmp_mask),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_addr(io_req_addr), .io_req_cmd(io_req_cmd),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_allow(io_resp_allow), .io_resp_hit(io_resp_hit), .io_resp_idx(io_resp_idx),
    .io_fault_valid(io_fault_valid), .io_fault_addr(io_fault_addr),
    .io_fault_cmd(io_fault_cmd), .io_fault_clr(io_fault_clr),
    .io_fault_count(io_fault_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic set_entry(input int i, input logic l, input logic [1:0] a,
                           input logic r, input logic w, input logic x,
                           input logic [31:0] baddr, input logic [31:0] mask);
    cfg_l[i] = l; cfg_a[2*i +: 2] = a; cfg_r[i] = r; cfg_w[i] = w; cfg_x[i] = x;
    pmp_addr[i*(PB-2) +: (PB-2)] = baddr[31:2];
    pmp_mask[i*PB +: PB] = mask;
  endtask

  // Hold a request until accepted; the expectation enters the scoreboard at accept
  task automatic issue(input logic [1:0] prv, input logic [31:0] addr,
                       input logic [1:0] cmd, input exp_t e);
    logic rdy;
    bit done;
    done = 0;
    io_prv = prv; io_req_addr = addr; io_req_cmd = cmd; io_req_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clock); rdy = io_req_ready;
      @(posedge clock); #1;
      if (rdy) begin done = 1; exp_q.push_back(e); end
    end
    io_req_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL issue_timeout addr=%h never accepted", addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_resp_valid, io_resp_allow, io_resp_hit, io_resp_idx, io_fault_valid} !== 7'b0) begin
      failures++; $display("FAIL reset_resp got=%b exp=0",
        {io_resp_valid, io_resp_allow, io_resp_hit, io_resp_idx, io_fault_valid});
    end
    checks++;
    if ({io_fault_addr, io_fault_cmd, io_fault_count} !== '0) begin
      failures++; $display("FAIL reset_fault addr=%h cmd=%0d cnt=%0d exp=0",
        io_fault_addr, io_fault_cmd, io_fault_count);
    end
    checks++;
    if (io_req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready got=%b exp=1", io_req_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_napot();
    exp_t e;
    set_entry(0, 0, 2'd3, 1, 0, 0, 32'h8000_0000, 32'h0000_0FFF);
    issue(2'b00, 32'h8000_0123, 2'd0, 5'b11000);
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b0) begin
      failures++; $display("FAIL napot_latency_early resp_valid=%b exp=0", io_resp_valid);
    end
    @(negedge clock);
    checks++;
    if (io_resp_valid !== 1'b1) begin
      failures++; $display("FAIL napot_latency resp_valid=%b exp=1", io_resp_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (obs !== e) begin
      failures++; $display("FAIL napot_resp got=%b exp=%b", obs, e);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_fault();
    exp_t e;
    bit got;
    issue(2'b00, 32'h8000_0123, 2'd1, 5'b01000);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (io_resp_valid) begin
        got = 1; e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL fault_resp got=%b exp=%b", obs, e); end
        @(posedge clock); #1;
      end
    end
    if (!got) begin checks++; failures++; $display("FAIL fault_timeout no response"); exp_q.delete(); end
    @(negedge clock);
    checks++;
    if ({io_fault_valid, io_fault_addr, io_fault_cmd} !== {1'b1, 32'h8000_0123, 2'd1}) begin
      failures++; $display("FAIL fault_capture v=%b addr=%h cmd=%0d exp v=1 addr=80000123 cmd=1",
        io_fault_valid, io_fault_addr, io_fault_cmd);
    end
    checks++;
    if (io_fault_count !== 4'd1) begin
      failures++; $display("FAIL fault_count got=%0d exp=1", io_fault_count);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_sticky();
    exp_t e;
    bit got;
    // Second denial must not overwrite the captured one
    issue(2'b00, 32'h8000_0456, 2'd2, 5'b01000);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (io_resp_valid) begin
        got = 1; e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL sticky_resp got=%b exp=%b", obs, e); end
        @(posedge clock); #1;
      end
    end
    if (!got) begin checks++; failures++; $display("FAIL sticky_timeout no response"); exp_q.delete(); end
    @(negedge clock);
    checks++;
    if ({io_fault_valid, io_fault_addr, io_fault_count} !== {1'b1, 32'h8000_0123, 4'd2}) begin
      failures++; $display("FAIL sticky_keep v=%b addr=%h cnt=%0d exp v=1 addr=80000123 cnt=2",
        io_fault_valid, io_fault_addr, io_fault_count);
    end
    @(posedge clock); #1;
    // Clear asserted exactly in the cycle the new denial fires
    issue(2'b00, 32'h0000_0010, 2'd0, 5'b00000);
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clock);
      if (io_resp_valid) begin
        got = 1; e = exp_q.pop_front(); checks++;
        if (obs !== e) begin failures++; $display("FAIL clr_resp got=%b exp=%b", obs, e); end
        io_fault_clr = 1'b1;
        @(posedge clock); #1;
        io_fault_clr = 1'b0;
      end
    end
    if (!got) begin checks++; failures++; $display("FAIL clr_timeout no response"); exp_q.delete(); end
    @(negedge clock);
    checks++;
    if ({io_fault_valid, io_fault_addr, io_fault_cmd, io_fault_count} !== {1'b1, 32'h0000_0010, 2'd0, 4'd3}) begin
      failures++; $display("FAIL clr_recapture v=%b addr=%h cmd=%0d cnt=%0d exp v=1 addr=00000010 cmd=0 cnt=3",
        io_fault_valid, io_fault_addr, io_fault_cmd, io_fault_count);
    end
    @(posedge clock); #1;
    // Clear alone drops the sticky flag, counter untouched
    io_fault_clr = 1'b1;
    @(posedge clock); #1;
    io_fault_clr = 1'b0;
    @(negedge clock);
    checks++;
    if ({io_fault_valid, io_fault_count} !== {1'b0, 4'd3}) begin
      failures++; $display("FAIL clr_only v=%b cnt=%0d exp v=0 cnt=3", io_fault_valid, io_fault_count);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_tor();
    logic [31:0] ta[5] = '{32'h0000_1FFC, 32'h0000_2000, 32'h0000_1000, 32'h0000_0FFC, 32'h0000_1800};
    logic [1:0]  tc[5] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
    exp_t        te[5] = '{5'b11001, 5'b00000, 5'b11001, 5'b00000, 5'b01001};
    exp_t e;
    bit got;
    set_entry(0, 0, 2'd0, 0, 0, 0, 32'h0000_1000, 32'h0);
    set_entry(1, 0, 2'd1, 0, 0, 1, 32'h0000_2000, 32'h0);
    set_entry(2, 0, 2'd3, 1, 0, 0, 32'h8000_0000, 32'h0000_0FFF);
    for (int k = 0; k < 5; k++) begin
      issue(2'b00, ta[k], tc[k], te[k]);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clock);
        if (io_resp_valid) begin
          got = 1; e = exp_q.pop_front(); checks++;
          if (obs !== e) begin failures++; $display("FAIL tor_resp addr=%h got=%b exp=%b", ta[k], obs, e); end
          @(posedge clock); #1;
        end
      end
      if (!got) begin checks++; failures++; $display("FAIL tor_timeout addr=%h", ta[k]); exp_q.delete(); end
    end
    @(negedge clock);
    checks++;
    if ({io_fault_valid, io_fault_addr, io_fault_cmd, io_fault_count} !== {1'b1, 32'h0000_2000, 2'd2, 4'd6}) begin
      failures++; $display("FAIL tor_fault v=%b addr=%h cmd=%0d cnt=%0d exp v=1 addr=00002000 cmd=2 cnt=6",
        io_fault_valid, io_fault_addr, io_fault_cmd, io_fault_count);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_mmode();
    logic [31:0] ta[3] = '{32'h0000_4000, 32'h0000_1800, 32'h0000_1800};
    logic [1:0]  tc[3] = '{2'd2, 2'd0, 2'd0};
    exp_t        te[3] = '{5'b10000, 5'b11001, 5'b01001};
    exp_t e;
    bit got;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) set_entry(1, 1, 2'd1, 0, 0, 1, 32'h0000_2000, 32'h0);
      issue(2'b11, ta[k], tc[k], te[k]);
      // Unlocking after accept must not change the in-flight locked result
      if (k == 2) set_entry(1, 0, 2'd1, 0, 0, 1, 32'h0000_2000, 32'h0);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clock);
        if (io_resp_valid) begin
          got = 1; e = exp_q.pop_front(); checks++;
          if (obs !== e) begin failures++; $display("FAIL mmode_resp[%0d] got=%b exp=%b", k, obs, e); end
          @(posedge clock); #1;
        end
      end
      if (!got) begin checks++; failures++; $display("FAIL mmode_timeout[%0d]", k); exp_q.delete(); end
    end
    @(negedge clock);
    checks++;
    if (io_fault_count !== 4'd7) begin
      failures++; $display("FAIL mmode_count got=%0d exp=7", io_fault_count);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ta[4] = '{32'h0000_1000, 32'h0000_4000, 32'h8000_0010, 32'h8000_0010};
    logic [1:0]  tc[4] = '{2'd2, 2'd2, 2'd0, 2'd1};
    exp_t        te[4] = '{5'b11001, 5'b00000, 5'b11010, 5'b01010};
    int n_acc;
    logic rdy;
    n_acc = 0;
    io_resp_ready = 1'b0;
    io_prv = 2'b00; io_req_addr = ta[0]; io_req_cmd = tc[0]; io_req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock); rdy = io_req_ready;
      @(posedge clock); #1;
      if (rdy) begin
        exp_q.push_back(te[n_acc]); n_acc++;
        io_req_addr = ta[n_acc]; io_req_cmd = tc[n_acc];
      end
    end
    checks++;
    if (n_acc !== 2) begin failures++; $display("FAIL b2b_accepted got=%0d exp=2", n_acc); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if ({io_req_ready, io_resp_valid, obs} !== {1'b0, 1'b1, 5'b11001}) begin
        failures++; $display("FAIL b2b_hold[%0d] rdy=%b vld=%b resp=%b exp rdy=0 vld=1 resp=11001",
          c, io_req_ready, io_resp_valid, obs);
      end
    end
    @(posedge clock); #1;
    io_resp_ready = 1'b1;
    fork
      begin
        for (int c = 0; c < 20 && n_acc < 4; c++) begin
          @(negedge clock); rdy = io_req_ready;
          @(posedge clock); #1;
          if (rdy) begin
            exp_q.push_back(te[n_acc]); n_acc++;
            if (n_acc < 4) begin io_req_addr = ta[n_acc]; io_req_cmd = tc[n_acc]; end
            else io_req_valid = 1'b0;
          end
        end
        io_req_valid = 1'b0;
      end
      begin
        int got;
        exp_t e;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
          @(negedge clock);
          if (io_resp_valid && io_resp_ready) begin
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL b2b_order[%0d] got=%b exp=%b", got, obs, e); end
            got++;
          end
        end
        if (got < 4) begin checks++; failures++; $display("FAIL b2b_timeout got=%0d of 4", got); end
      end
    join
    exp_q.delete();
    @(negedge clock);
    checks++;
    if (io_fault_count !== 4'd9) begin failures++; $display("FAIL b2b_count got=%0d exp=9", io_fault_count); end
    @(posedge clock); #1;
  endtask

  task automatic test_saturate();
    fork
      begin
        for (int k = 0; k < 8; k++) issue(2'b00, 32'h0000_4000, 2'd2, 5'b00000);
      end
      begin
        int got;
        exp_t e;
        got = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
          @(negedge clock);
          if (io_resp_valid && io_resp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front(); checks++;
            if (obs !== e) begin failures++; $display("FAIL sat_resp[%0d] got=%b exp=%b", got, obs, e); end
            got++;
          end
        end
        if (got < 8) begin checks++; failures++; $display("FAIL sat_timeout got=%0d of 8", got); end
      end
    join
    exp_q.delete();
    @(negedge clock);
    checks++;
    if (io_fault_count !== 4'hF) begin failures++; $display("FAIL sat_count got=%0d exp=15", io_fault_count); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(2'b00, 32'h0000_1000, 2'd2, 5'b11001);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_q.delete();
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (io_resp_valid) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL reset_mid_resp response emitted for dropped request"); end
    checks++;
    if ({io_fault_valid, io_fault_count} !== {1'b0, 4'd0}) begin
      failures++; $display("FAIL reset_mid_state v=%b cnt=%0d exp v=0 cnt=0", io_fault_valid, io_fault_count);
    end
  endtask

  initial begin
    reset = 1'b1; io_prv = '0; io_req_valid = 1'b0; io_req_addr = '0; io_req_cmd = '0;
    io_resp_ready = 1'b1; io_fault_clr = 1'b0;
    cfg_l = '0; cfg_a = '0; cfg_r = '0; cfg_w = '0; cfg_x = '0; pmp_addr = '0; pmp_mask = '0;
    test_reset();
    test_napot();
    test_fault();
    test_sticky();
    test_tor();
    test_mmode();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
